// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: fork/join controller for NPROC processes with join, join_any and join_none.
// Optional watchdog enabled by defining FJ_TIMEOUT_EN.
module fork_join_ctrl #(
    parameter int NPROC   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [NPROC-1:0] done_i,
    output logic [NPROC-1:0] fork_o,
    output logic             join_o,
    output logic             cont_o,
    output logic [2:0]       first_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             timeout_o
);
    typedef enum logic [1:0] {IDLE, FORK, WAIT, DRAIN} state_t;
    localparam logic [1:0] M_JOIN = 2'b00;
    localparam logic [1:0] M_ANY  = 2'b01;
    localparam logic [1:0] M_NONE = 2'b10;

    if (NPROC < 2 || NPROC > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("fork_join_ctrl: NPROC must be 2..8 and TIMEOUT >= 1");
    end

    state_t           state;
    logic [1:0]       mode;
    logic [NPROC-1:0] pending;
    logic             joined;
    logic             cont_due;
    logic             got_first;
    logic [2:0]       first_idx;
    logic [NPROC-1:0] valid;
    logic [2:0]       low;
    logic [2:0]       first_val;

`ifdef FJ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`endif

    assign valid     = done_i & pending;
    assign first_val = got_first ? first_idx : low;

    // lowest-index finisher among this cycle's valid dones
    always_comb begin
        low = '0;
        for (int i = NPROC - 1; i >= 0; i--)
            if (valid[i]) low = 3'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode      <= M_JOIN;
            pending   <= '0;
            joined    <= 1'b0;
            cont_due  <= 1'b0;
            got_first <= 1'b0;
            first_idx <= '0;
            fork_o    <= '0;
            join_o    <= 1'b0;
            cont_o    <= 1'b0;
            first_o   <= '0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
            timeout_o <= 1'b0;
`ifdef FJ_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            fork_o    <= '0;
            join_o    <= 1'b0;
            cont_o    <= 1'b0;
            first_o   <= '0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    state     <= FORK;
                    mode      <= (mode_i == 2'b11) ? M_JOIN : mode_i;
                    err_o     <= 1'b0;
                    fork_o    <= '1;
                    busy_o    <= 1'b1;
                    pending   <= '1;
                    join_o    <= (mode_i == M_NONE);
                    joined    <= (mode_i == M_NONE);
                    cont_due  <= 1'b0;
                    got_first <= 1'b0;
                    first_idx <= '0;
`ifdef FJ_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                FORK: begin
                    if (|done_i) err_o <= 1'b1;
                    state <= (mode == M_NONE) ? DRAIN : WAIT;
                end
                default: begin
                    if (|(done_i & ~pending)) err_o <= 1'b1;
                    pending <= pending & ~done_i;
                    if (|valid && !got_first) begin
                        got_first <= 1'b1;
                        first_idx <= low;
                    end
                    if (cont_due) begin
                        cont_o   <= 1'b1;
                        cont_due <= 1'b0;
                    end
                    if (pending == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (state == WAIT && mode == M_ANY && |valid) begin
                        join_o   <= 1'b1;
                        first_o  <= low;
                        joined   <= 1'b1;
                        cont_due <= 1'b1;
                        state    <= DRAIN;
                    end else if (state == WAIT && mode == M_JOIN && (pending & ~done_i) == '0) begin
                        join_o  <= 1'b1;
                        first_o <= first_val;
                        joined  <= 1'b1;
                    end
`ifdef FJ_TIMEOUT_EN
                    // watchdog overrides normal completion in the cycle it expires
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        err_o     <= 1'b1;
                        pending   <= '0;
                        cont_due  <= 1'b0;
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        cnt       <= '0;
                        if (!joined) begin
                            join_o  <= 1'b1;
                            first_o <= first_val;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fork_join_ctrl.sv
// tb_fork_join_ctrl: directed and randomized checks of fork_join_ctrl against a timeline model.
module tb_fork_join_ctrl;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   mode;
    logic [N-1:0] done;
    logic [N-1:0] fork_o;
    logic         join_o, cont_o, busy_o, err_o, timeout_o;
    logic [2:0]   first_o;

    int checks = 0;
    int errors = 0;

    fork_join_ctrl #(.NPROC(N), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .done_i(done),
        .fork_o(fork_o), .join_o(join_o), .cont_o(cont_o), .first_o(first_o),
        .busy_o(busy_o), .err_o(err_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Timeline model: every edge is numbered; events are scheduled relative to
    // the accepting edge, the first finishing edge and the edge pending empties.
    int           e = 0, t0, empty_e, first_e, first_idx;
    logic         m_busy = 1'b0, m_err = 1'b0, got_first;
    logic [1:0]   md;
    logic [N-1:0] pend;
    logic [N-1:0] exp_fork = '0;
    logic         exp_join = 1'b0, exp_cont = 1'b0;
    int           exp_first = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_err = 1'b0; pend = '0;
            exp_fork = '0; exp_join = 1'b0; exp_cont = 1'b0; exp_first = 0;
        end else begin
            int lo;
            e++;
            exp_fork = '0; exp_join = 1'b0; exp_cont = 1'b0; exp_first = 0;
            if (!m_busy) begin
                if (start) begin
                    t0 = e; md = (mode == 2'b11) ? 2'b00 : mode;
                    m_err = 1'b0; pend = '1; m_busy = 1'b1; exp_fork = '1;
                    empty_e = -10; first_e = -10; got_first = 1'b0; first_idx = 0;
                    exp_join = (md == 2'b10);
                end
            end else if (e == t0 + 1) begin
                if (done != '0) m_err = 1'b1;
            end else begin
                if (e == empty_e + 1) m_busy = 1'b0;
                lo = -1;
                for (int i = 0; i < N; i++) begin
                    if (done[i]) begin
                        if (pend[i]) begin
                            pend[i] = 1'b0;
                            if (lo < 0) lo = i;
                        end else m_err = 1'b1;
                    end
                end
                if (lo >= 0 && !got_first) begin
                    got_first = 1'b1; first_idx = lo;
                    if (md == 2'b01) begin exp_join = 1'b1; exp_first = lo; first_e = e; end
                end
                if (e == first_e + 1) exp_cont = 1'b1;
                if (pend == '0 && empty_e < 0) begin
                    empty_e = e;
                    if (md == 2'b00) begin exp_join = 1'b1; exp_first = first_idx; end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fork", 8'(fork_o), 8'(exp_fork));
        chk("join", 8'(join_o), 8'(exp_join));
        chk("cont", 8'(cont_o), 8'(exp_cont));
        chk("first", 8'(first_o), 8'(exp_first));
        chk("busy", 8'(busy_o), 8'(m_busy));
        chk("err", 8'(err_o), 8'(m_err));
        chk("timeout", 8'(timeout_o), 8'd0);
    end

    task automatic step(input logic s, input logic [1:0] m, input logic [N-1:0] d);
        start = s; mode = m; done = d;
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic do_reset;
        start = 1'b0; done = '0; rst_n = 1'b0; #1;
        chk("rst_fork", 8'(fork_o), 8'd0);
        chk("rst_join", 8'(join_o), 8'd0);
        chk("rst_cont", 8'(cont_o), 8'd0);
        chk("rst_first", 8'(first_o), 8'd0);
        chk("rst_busy", 8'(busy_o), 8'd0);
        chk("rst_err", 8'(err_o), 8'd0);
        @(posedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; mode = 2'b00; done = '0;
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        do_reset();
        step(0, 0, 0);
        // join: done 01 at t+3, 10 at t+5
        step(1, 2'b00, 2'b00);
        chk("j_fork", 8'(fork_o), 8'h03);
        chk("j_busy", 8'(busy_o), 8'h01);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 2'b01); step(0, 0, 0);
        step(0, 0, 2'b10);
        chk("j_join", 8'(join_o), 8'h01);
        step(0, 0, 0);
        chk("j_idle", 8'(busy_o), 8'h00);
        // join_any: done 10 at t+3, 01 at t+8
        step(1, 2'b01, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 2'b10);
        chk("a_join", 8'(join_o), 8'h01);
        chk("a_first", 8'(first_o), 8'h01);
        step(0, 0, 0);
        chk("a_cont", 8'(cont_o), 8'h01);
        chk("a_first0", 8'(first_o), 8'h00);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 2'b01);
        chk("a_busy9", 8'(busy_o), 8'h01);
        step(0, 0, 0);
        chk("a_idle", 8'(busy_o), 8'h00);
        // join_none
        step(1, 2'b10, 0);
        chk("n_join", 8'(join_o), 8'h01);
        chk("n_fork", 8'(fork_o), 8'h03);
        step(0, 0, 0); step(0, 0, 2'b11); step(0, 0, 0);
        chk("n_idle", 8'(busy_o), 8'h00);
        // join_any with simultaneous done
        step(1, 2'b01, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 2'b11);
        chk("s_join", 8'(join_o), 8'h01);
        chk("s_first", 8'(first_o), 8'h00);
        step(0, 0, 0);
        chk("s_cont", 8'(cont_o), 8'h01);
        step(0, 0, 0);
        // double done and start during busy
        step(1, 2'b11, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 2'b01); step(0, 0, 2'b01);
        chk("e_err", 8'(err_o), 8'h01);
        step(1, 2'b00, 0);
        chk("e_nofork", 8'(fork_o), 8'h00);
        step(0, 0, 2'b10);
        chk("e_join", 8'(join_o), 8'h01);
        step(0, 0, 0);
        chk("e_sticky", 8'(err_o), 8'h01);
        step(1, 2'b01, 0);
        chk("e_clear", 8'(err_o), 8'h00);
        step(0, 0, 0); step(0, 0, 2'b11); step(0, 0, 0); step(0, 0, 0);
        // reset in WAIT aborts without join
        step(1, 2'b00, 0); step(0, 0, 0); step(0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            chk("r_nojoin", 8'(join_o), 8'h00);
        end
        step(1, 2'b00, 0);
        chk("r_fork", 8'(fork_o), 8'h03);
        step(0, 0, 0); step(0, 0, 2'b11);
        chk("r_join", 8'(join_o), 8'h01);
        step(0, 0, 0);
        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else begin
                logic [N-1:0] d;
                for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 5) == 0);
                step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), d);
            end
        end
        step(0, 0, 0); step(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
